// File: rtl/uncache_axi_bridge_pkg.sv
// Shared encodings for the uncached AXI bridge: burst/resp codes, size codes,
// the FSM state enum and the latched request record.
package uncache_axi_bridge_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] SIZE_BYTE   = 2'd0;
    localparam logic [1:0] SIZE_HALF   = 2'd1;
    localparam logic [1:0] SIZE_WORD   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_AR  = 3'd1,
        ST_RD_R   = 3'd2,
        ST_WR_AWW = 3'd3,
        ST_WR_B   = 3'd4
    } state_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] paddr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/uncache_axi_bridge.sv
// Uncached data access engine: one single-beat AXI read or write per LSU request.
// Latency: accept T0, address/data handshake T1, r/b beat T2, resp_valid pulse T3 (ready slaves).
// Backpressure: req_ready only in IDLE; every AXI valid is registered and held until its handshake.
module uncache_axi_bridge
    import uncache_axi_bridge_pkg::*;
#(
    parameter int                  AXI_ID_W = 4,
    parameter logic [AXI_ID_W-1:0] AXI_ID   = AXI_ID_W'(1)
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [31:0]         req_paddr,
    input  logic [1:0]          req_size,
    input  logic [3:0]          req_wstrb,
    input  logic [31:0]         req_wdata,

    output logic                resp_valid,
    output logic [31:0]         resp_rdata,
    output logic                resp_err,

    output logic [AXI_ID_W-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,

    input  logic [AXI_ID_W-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,

    output logic [AXI_ID_W-1:0] awid,
    output logic [31:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,

    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,

    input  logic [AXI_ID_W-1:0] bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    state_t state;
    req_t   req_q;
    logic   aw_done;
    logic   w_done;
    logic   aw_fire;
    logic   w_fire;

    assign req_ready = (state == ST_IDLE);
    assign aw_fire   = awvalid & awready;
    assign w_fire    = wvalid & wready;

    // Address/data channels are driven straight from the latched request.
    assign arid    = AXI_ID;
    assign araddr  = req_q.paddr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, req_q.size};
    assign arburst = BURST_INCR;

    assign awid    = AXI_ID;
    assign awaddr  = req_q.paddr;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, req_q.size};
    assign awburst = BURST_INCR;

    assign wdata   = req_q.wdata;
    assign wstrb   = req_q.wstrb;
    assign wlast   = 1'b1;

    logic unused_inputs;
    assign unused_inputs = ^{rid, bid, rlast, rresp[0], bresp[0], req_q.wr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q <= '{wr: req_wr, paddr: req_paddr, size: req_size,
                                   wstrb: req_wstrb, wdata: req_wdata};
                        if (req_wr) begin
                            state   <= ST_WR_AWW;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                        end else begin
                            state   <= ST_RD_AR;
                            arvalid <= 1'b1;
                        end
                    end
                end
                ST_RD_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata;
                        resp_err   <= rresp[1];
                        state      <= ST_IDLE;
                    end
                end
                ST_WR_AWW: begin
                    // AW and W complete independently; move on once both have gone.
                    if (aw_fire) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done | aw_fire) & (w_done | w_fire)) begin
                        bready <= 1'b1;
                        state  <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= bresp[1];
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
